// File: rtl/guess_game_ctrl.sv
// Number-guessing game controller: free-running LFSR secret source, synchronised
// pushbutton press detection, game FSM, saturating BCD guess counter and guess limit.
module guess_game_ctrl #(
    parameter int unsigned      WIDTH       = 10,
    parameter int unsigned      DIGITS      = 2,
    parameter int unsigned      MAX_GUESSES = 0,
    parameter logic [WIDTH-1:0] SEED        = 1,
    parameter logic [WIDTH-1:0] TAPS        = 10'h240
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start_button,
    input  logic                  Guess_button,
    input  logic [WIDTH-1:0]      guess,
    output logic [2:0]            state,
    output logic [4*DIGITS-1:0]   count,
    output logic [WIDTH-1:0]      secret,
    output logic                  guess_pulse
);

    localparam int unsigned CW = $clog2(10**DIGITS) + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PLAY = 3'd1,
        LOW  = 3'd2,
        HIGH = 3'd3,
        HIT  = 3'd4,
        LOSE = 3'd5
    } state_t;

    state_t              st;
    logic [WIDTH-1:0]    lfsr;
    logic [CW-1:0]       bin;
    logic                st_s1, st_s2, st_s3;
    logic                gu_s1, gu_s2, gu_s3;
    logic                start_press, guess_press;
    logic [4*DIGITS-1:0] count_inc;
    logic                carry;
    logic                all_nines;
    logic [CW-1:0]       bin_inc;
    logic                limit_reached;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            {st_s1, st_s2, st_s3} <= 3'b111;
            {gu_s1, gu_s2, gu_s3} <= 3'b111;
        end else begin
            st_s1 <= Start_button;
            st_s2 <= st_s1;
            st_s3 <= st_s2;
            gu_s1 <= Guess_button;
            gu_s2 <= gu_s1;
            gu_s3 <= gu_s2;
        end
    end

    // Active-low buttons: a press is the synchronised 1->0 transition.
    assign start_press = st_s3 & ~st_s2;
    assign guess_press = gu_s3 & ~gu_s2;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            lfsr <= SEED;
        end else if (lfsr == '0) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
        end
    end

    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry               = 1'b0;
                end
            end
        end
    end

    assign all_nines     = (count == {DIGITS{4'h9}});
    assign bin_inc       = (&bin) ? bin : bin + 1'b1;
    assign limit_reached = (MAX_GUESSES != 0) && (bin_inc == CW'(MAX_GUESSES));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            st          <= IDLE;
            count       <= '0;
            secret      <= '0;
            bin         <= '0;
            guess_pulse <= 1'b0;
        end else begin
            guess_pulse <= 1'b0;
            if (start_press) begin
                secret <= lfsr;
                count  <= '0;
                bin    <= '0;
                st     <= PLAY;
            end else begin
                case (st)
                    IDLE, HIT, LOSE: ;
                    PLAY, LOW, HIGH: begin
                        if (guess_press) begin
                            guess_pulse <= 1'b1;
                            if (!all_nines) count <= count_inc;
                            bin <= bin_inc;
                            if (guess == secret)  st <= HIT;
                            else if (limit_reached) st <= LOSE;
                            else if (guess < secret) st <= LOW;
                            else                  st <= HIGH;
                        end
                    end
                    default: st <= IDLE;
                endcase
            end
        end
    end

    assign state = st;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed + randomized bench for guess_game_ctrl: an unlimited instance and a
// three-guess-limit instance share stimulus and are checked against a game model.
module tb_guess_game_ctrl;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Start_button, Guess_button;
    logic [9:0] guess;

    logic [2:0] state0, state1;
    logic [7:0] count0, count1;
    logic [9:0] secret0, secret1;
    logic       pulse0, pulse1;

    int checks   = 0;
    int failures = 0;
    int edges;

    int         m_st[2];
    int         m_cnt[2];
    int         m_bin[2];
    int         m_pulse[2];
    logic [9:0] m_sec[2];
    int         lim[2] = '{0, 3};

    guess_game_ctrl #(.WIDTH(10), .DIGITS(2), .MAX_GUESSES(0), .SEED(10'd1), .TAPS(10'h240)) u_free (
        .Clock(Clock), .Reset(Reset), .Start_button(Start_button), .Guess_button(Guess_button),
        .guess(guess), .state(state0), .count(count0), .secret(secret0), .guess_pulse(pulse0));

    guess_game_ctrl #(.WIDTH(10), .DIGITS(2), .MAX_GUESSES(3), .SEED(10'd1), .TAPS(10'h240)) u_lim (
        .Clock(Clock), .Reset(Reset), .Start_button(Start_button), .Guess_button(Guess_button),
        .guess(guess), .state(state1), .count(count1), .secret(secret1), .guess_pulse(pulse1));

    always #5 Clock = ~Clock;

    always @(posedge Clock or negedge Reset) begin
        if (!Reset) edges <= 0;
        else        edges <= edges + 1;
    end

    // Value of a Fibonacci LFSR (x^10+x^7+1) after n steps from seed 1.
    function automatic logic [9:0] lfsr_at(input int n);
        logic [9:0] v = 10'd1;
        for (int i = 0; i < n; i++) begin
            if (v == 10'd0) v = 10'd1;
            else            v = {v[8:0], v[9] ^ v[6]};
        end
        return v;
    endfunction

    function automatic logic [7:0] to_bcd(input int c);
        return 8'(((c / 10) << 4) | (c % 10));
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/state0"},  32'(state0),  32'(m_st[0]));
        chk({tag, "/count0"},  32'(count0),  32'(to_bcd(m_cnt[0])));
        chk({tag, "/secret0"}, 32'(secret0), 32'(m_sec[0]));
        chk({tag, "/pulse0"},  32'(pulse0),  32'(m_pulse[0]));
        chk({tag, "/state1"},  32'(state1),  32'(m_st[1]));
        chk({tag, "/count1"},  32'(count1),  32'(to_bcd(m_cnt[1])));
        chk({tag, "/secret1"}, 32'(secret1), 32'(m_sec[1]));
        chk({tag, "/pulse1"},  32'(pulse1),  32'(m_pulse[1]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_cnt[i] = 0; m_bin[i] = 0; m_pulse[i] = 0; m_sec[i] = '0;
        end
    endtask

    // Game rules applied at the update edge; n = edges elapsed since reset incl. that edge.
    task automatic model_apply(input bit st_b, input bit gu_b, input logic [9:0] g, input int n);
        for (int i = 0; i < 2; i++) begin
            m_pulse[i] = 0;
            if (st_b) begin
                m_sec[i] = lfsr_at(n - 1);
                m_cnt[i] = 0; m_bin[i] = 0; m_st[i] = 1;
            end else if (gu_b && (m_st[i] >= 1 && m_st[i] <= 3)) begin
                m_pulse[i] = 1;
                if (m_cnt[i] < 99) m_cnt[i]++;
                m_bin[i]++;
                if (g == m_sec[i])                          m_st[i] = 4;
                else if (lim[i] != 0 && m_bin[i] == lim[i]) m_st[i] = 5;
                else if (g < m_sec[i])                      m_st[i] = 2;
                else                                        m_st[i] = 3;
            end
        end
    endtask

    task automatic press(input string tag, input bit st_b, input bit gu_b, input logic [9:0] g, input int hold);
        @(negedge Clock);
        Start_button = !st_b;
        Guess_button = !gu_b;
        guess = g;
        repeat (2) @(posedge Clock);
        @(negedge Clock);
        check_all({tag, "/pre"});
        @(negedge Clock);
        model_apply(st_b, gu_b, g, edges);
        check_all(tag);
        m_pulse[0] = 0;
        m_pulse[1] = 0;
        repeat (hold) begin
            @(negedge Clock);
            check_all({tag, "/hold"});
        end
        Start_button = 1'b1;
        Guess_button = 1'b1;
        repeat (4) @(negedge Clock);
        check_all({tag, "/after"});
    endtask

    function automatic logic [9:0] wrong_for(input logic [9:0] s);
        return 10'((32'(s) + 1 + $urandom_range(0, 1000)) % 1024);
    endfunction

    initial begin
        Reset = 1'b0; Start_button = 1'b1; Guess_button = 1'b1; guess = '0;
        model_reset();
        repeat (3) @(negedge Clock);
        check_all("reset");
        Reset = 1'b1;
        repeat (4) begin
            @(negedge Clock);
            check_all("idle");
        end

        // Start lands on edge 8: secret is the LFSR after 7 steps; held button is one press.
        press("start_hold", 1'b1, 1'b0, '0, 20);
        chk("secret129", 32'(secret0), 32'd129);

        press("g100", 1'b0, 1'b1, 10'd100, 0);
        press("g200", 1'b0, 1'b1, 10'd200, 0);
        press("g129", 1'b0, 1'b1, 10'd129, 0);
        press("g_after_hit", 1'b0, 1'b1, 10'd5, 0);

        press("start2", 1'b1, 1'b0, '0, 0);
        for (int i = 0; i < 4; i++) press("wrong", 1'b0, 1'b1, wrong_for(m_sec[0]), 0);
        chk("lose_state", 32'(state1), 32'd5);
        press("start3", 1'b1, 1'b0, '0, 0);

        // Saturation run: 100 misses on the unlimited instance.
        for (int i = 0; i < 100; i++) press("sat", 1'b0, 1'b1, wrong_for(m_sec[0]), 0);
        chk("count_sat", 32'(count0), 32'h99);

        press("start4", 1'b1, 1'b0, '0, 0);
        press("start_and_guess", 1'b1, 1'b1, m_sec[0], 0);

        for (int game = 0; game < 4; game++) begin
            press("rstart", 1'b1, 1'b0, '0, $urandom_range(0, 3));
            for (int k = 0; k < 6; k++) begin
                logic [9:0] g;
                g = ($urandom_range(0, 3) == 0) ? m_sec[0] : 10'($urandom_range(0, 1023));
                press("rguess", 1'b0, 1'b1, g, 0);
            end
        end

        press("start5", 1'b1, 1'b0, '0, 0);
        press("go_high", 1'b0, 1'b1, (m_sec[0] == 10'h3FF) ? 10'd0 : m_sec[0] + 10'd1, 0);
        @(negedge Clock);
        #2 Reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge Clock);
        Reset = 1'b1;
        press("guess_in_idle", 1'b0, 1'b1, 10'd7, 0);
        press("start6", 1'b1, 1'b0, '0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/guess_game_ctrl.md
Name: guess_game_ctrl

Overview:
Parametrised controller for the number-guessing game. It owns the secret generator (free-running LFSR), button synchronisation with press detection, the game state machine, a multi-digit BCD guess counter and an optional guess limit with a LOSE outcome. Its state code drives the existing 7-segment output mux. It replaces the separate LFSR, guess-counter and button FSM blocks.

Parameters:
WIDTH, 10, width of guess, secret and LFSR
DIGITS, 2, number of BCD digits in the guess counter
MAX_GUESSES, 0, guess limit; 0 = unlimited; otherwise 1 .. (10^DIGITS - 1)
SEED, 1, LFSR reset value; must be nonzero
TAPS, 10'h240, LFSR feedback mask (default x^10+x^7+1, maximal length)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low
Start_button  in  1  active-low pushbutton, asynchronous to Clock
Guess_button  in  1  active-low pushbutton, asynchronous to Clock
guess  in  WIDTH  switch value; sampled on an accepted guess press
state  out  3  0=IDLE, 1=PLAY, 2=LOW, 3=HIGH, 4=HIT, 5=LOSE
count  out  4*DIGITS  BCD guess count; digit 0 in [3:0]
secret  out  WIDTH  current secret value
guess_pulse  out  1  high for one cycle when a guess is accepted

Behaviour:
- Reset asserted (asynchronous): state=0, count=0, secret=0, guess_pulse=0, lfsr=SEED, all synchroniser and edge flops=1 (released).
- Buttons: each button passes through a 2-flop synchroniser (s1, s2) and a history flop s3.
- press = s3 & ~s2. The press is a single-cycle event per falling edge. A held button produces no repeat presses.
- Latency: the input falls before edge E0. The press is visible after edge E1. The state, count and secret update at E2.
- LFSR: advances every cycle in every state. next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)}.
- If the LFSR ever holds 0, it reloads SEED on the next cycle.
- Start press (any state, including IDLE, HIT and LOSE):
  - secret <= current lfsr
  - count <= 0
  - internal binary guess counter <= 0
  - state <= PLAY
- Guess press in PLAY, LOW or HIGH, using the guess value present at the update edge:
  - guess_pulse=1 for that cycle.
  - count increments in BCD (digit wraps 9->0 with carry). It saturates at all-9s and never wraps to 0.
  - The binary counter increments (saturating).
  - Unsigned compare: guess < secret -> LOW; guess > secret -> HIGH; guess == secret -> HIT.
  - If MAX_GUESSES != 0, the incremented binary count == MAX_GUESSES, and guess != secret -> LOSE instead of LOW/HIGH.
  - A hit on the final allowed guess -> HIT.
- Guess press in IDLE, HIT or LOSE: ignored. No count change, no guess_pulse.
- Start and guess presses in the same cycle: start wins; the guess is discarded (no pulse, no count).
- secret is held constant from the start press until the next start press or reset.
- Reset asserted mid-game: immediate return to reset values. After release, the state stays IDLE until a start press.
- States 6 and 7 are unreachable. If entered, the next edge forces IDLE.
- No combinational path from any input to any output.

Test Plan:
1. Reset, release, hold buttons high for 6 cycles (defaults) -> state=0, count=00. LFSR after 1..7 edges = 2,4,8,16,32,64,129.
2. Start press -> state=1 exactly 3 edges after the button fall. secret equals the LFSR value at that edge. count=00. Holding Start low for 20 cycles -> no further secret change.
3. secret=129; guesses 100, 200, 129 -> state 2, 3, 4. count=01, 02, 03. One guess_pulse per press. A 4th guess after HIT -> ignored (count stays 03).
4. MAX_GUESSES=3: three wrong guesses -> LOSE after the 3rd, count=03. A further guess is ignored. A start press -> PLAY, count=00.
5. DIGITS=2: 99 wrong guesses -> count=99. 100th guess -> count stays 99. Count rolls through 09->10 and 19->20 correctly.
6. Start and guess falling in the same cycle while in PLAY -> secret reloads, count=00, guess_pulse=0. Reset pulse mid-HIGH -> all outputs return to reset values immediately, without waiting for Clock.
